tile_sequencer: RTL

//  Instruction-driven scheduler for the 4x4 systolic array. Fetches size words from instr memory and

---
 rtl/tile_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tile_sequencer.sv
// tile_sequencer: instruction-driven scheduler splitting NxN matmuls into 4x4 tiles for the systolic array.
// Optional PERF_CNT_EN adds perf_cyc/perf_wait cycle counters.
module tile_sequencer #(
   parameter int unsigned PC_W  = 5,
   parameter logic [31:0] A_B4  = 32'd0,
   parameter logic [31:0] A_B8  = 32'd2048,
   parameter logic [31:0] A_B16 = 32'd8192,
   parameter logic [31:0] B_B4  = 32'd256,
   parameter logic [31:0] B_B8  = 32'd4096,
   parameter logic [31:0] B_B16 = 32'd12288,
   parameter logic [31:0] O_B4  = 32'd512,
   parameter logic [31:0] O_B8  = 32'd6144,
   parameter logic [31:0] O_B16 = 32'd16384
) (
   input  logic        clk,
   input  logic        rst,
`ifdef PERF_CNT_EN
   output logic [31:0] perf_cyc,
   output logic [31:0] perf_wait,
`endif
   input  logic        ap_start,
   output logic        ap_done,
   output logic        busy,
   output logic        err,
   output logic [31:0] addrI,
   output logic        enI,
   input  logic [31:0] dataI,
   output logic [31:0] addrA,
   output logic        enA,
   output logic [31:0] addrB,
   output logic        enB,
   output logic        ld_valid,
   output logic [3:0]  ld_idx,
   output logic        arr_go,
   output logic        acc_clr,
   input  logic        arr_done,
   output logic        arr_store,
   output logic [31:0] out_addr,
   input  logic        wb_done
);
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_FEED, S_GO, S_WAIT_ARR, S_STORE, S_WAIT_WB, S_DONE
   } state_t;
   state_t state_q, state_d;
   // pc carries one extra bit so running off the end of the program is detectable
   logic [PC_W:0] pc_q, pc_d;
   logic [1:0] code_q, code_d, ti_q, ti_d, tj_q, tj_d, kb_q, kb_d, nb;
   logic [3:0] cnt_q, cnt_d, ldi_q;
   logic err_q, err_d, ldv_q;
   logic [31:0] base_a, base_b, base_o;
   logic [4:0] sh;
   logic unused_bits;
   assign unused_bits = ^dataI[31:2];
   assign nb     = code_q == 2'd0 ? 2'd0 : code_q == 2'd1 ? 2'd1 : 2'd3;
   assign sh     = {3'b000, code_q} + 5'd2;
   assign base_a = code_q == 2'd0 ? A_B4 : code_q == 2'd1 ? A_B8 : A_B16;
   assign base_b = code_q == 2'd0 ? B_B4 : code_q == 2'd1 ? B_B8 : B_B16;
   assign base_o = code_q == 2'd0 ? O_B4 : code_q == 2'd1 ? O_B8 : O_B16;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         code_q  <= '0;
         ti_q    <= '0;
         tj_q    <= '0;
         kb_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         ldv_q   <= 1'b0;
         ldi_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         code_q  <= code_d;
         ti_q    <= ti_d;
         tj_q    <= tj_d;
         kb_q    <= kb_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ldv_q   <= state_q == S_FEED;
         ldi_q   <= state_q == S_FEED ? cnt_q : 4'd0;
      end
   end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      code_d  = code_q;
      ti_d    = ti_q;
      tj_d    = tj_q;
      kb_d    = kb_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: if (ap_start) begin
            pc_d    = '0;
            err_d   = 1'b0;
            state_d = S_FETCH;
         end
         S_FETCH: if (pc_q[PC_W]) begin
            err_d   = 1'b1;
            state_d = S_DONE;
         end else state_d = S_DECODE;
         S_DECODE: if (dataI[1:0] == 2'd3) state_d = S_DONE;
         else begin
            code_d  = dataI[1:0];
            ti_d    = '0;
            tj_d    = '0;
            kb_d    = '0;
            cnt_d   = '0;
            pc_d    = pc_q + {{PC_W{1'b0}}, 1'b1};
            state_d = S_FEED;
         end
         S_FEED: begin
            cnt_d   = cnt_q + 4'd1;
            state_d = cnt_q == 4'd15 ? S_GO : S_FEED;
         end
         S_GO: state_d = S_WAIT_ARR;
         // cnt has wrapped back to 0, so the next k-block feed starts cleanly
         S_WAIT_ARR: if (arr_done) begin
            kb_d    = kb_q != nb ? kb_q + 2'd1 : kb_q;
            state_d = kb_q != nb ? S_FEED : S_STORE;
         end
         S_STORE: state_d = S_WAIT_WB;
         S_WAIT_WB: if (wb_done) begin
            kb_d    = '0;
            tj_d    = tj_q == nb ? 2'd0 : tj_q + 2'd1;
            ti_d    = tj_q == nb ? (ti_q == nb ? 2'd0 : ti_q + 2'd1) : ti_q;
            state_d = (tj_q == nb && ti_q == nb) ? S_FETCH : S_FEED;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   assign busy      = state_q != S_IDLE;
   assign ap_done   = state_q == S_DONE;
   assign err       = err_q;
   assign enI       = state_q == S_FETCH && !pc_q[PC_W];
   assign addrI     = enI ? 32'(pc_q[PC_W-1:0]) : 32'd0;
   assign enA       = state_q == S_FEED;
   assign enB       = enA;
   assign addrA     = enA ? base_a + (32'({ti_q, cnt_q[3:2]}) << sh) + 32'({kb_q, cnt_q[1:0]}) : 32'd0;
   assign addrB     = enB ? base_b + (32'({kb_q, cnt_q[3:2]}) << sh) + 32'({tj_q, cnt_q[1:0]}) : 32'd0;
   assign ld_valid  = ldv_q;
   assign ld_idx    = ldi_q;
   assign arr_go    = state_q == S_GO;
   assign acc_clr   = arr_go && kb_q == 2'd0;
   assign arr_store = state_q == S_STORE;
   assign out_addr  = arr_store ? base_o + (32'({ti_q, 2'b00}) << sh) + 32'({tj_q, 2'b00}) : 32'd0;
`ifdef PERF_CNT_EN
   logic [31:0] perf_cyc_q, perf_wait_q;
   always_ff @(posedge clk) begin
      if (rst || (state_q == S_IDLE && ap_start)) begin
         perf_cyc_q  <= '0;
         perf_wait_q <= '0;
      end else begin
         perf_cyc_q  <= busy ? perf_cyc_q + 32'd1 : perf_cyc_q;
         perf_wait_q <= (state_q == S_WAIT_ARR || state_q == S_WAIT_WB) ? perf_wait_q + 32'd1 : perf_wait_q;
      end
   end
   assign perf_cyc  = perf_cyc_q;
   assign perf_wait = perf_wait_q;
`endif
endmodule
